// File: rtl/led_fader.sv
// -----------------------------------------------------------------------------
// led_fader
//
// Turns a per-channel on/off LED request into a PWM drive whose brightness
// ramps smoothly toward the requested state. Every channel is independent;
// all channels share one brightness prescaler and one PWM counter.
//
// Ports:
//   clk      in   1       system clock, rising edge
//   rst_n    in   1       asynchronous active-low reset
//   led_req  in   NUM_CH  requested LED state per channel (1 = on)
//   led_out  out  NUM_CH  PWM-modulated LED drive, registered
//   fading   out  NUM_CH  1 while a channel's level has not reached its target
//
// Parameters:
//   NUM_CH    number of LED channels
//   PWM_BITS  brightness / PWM resolution, MAX level = 2^PWM_BITS - 1
//   STEP_DIV  clocks per brightness step (>= 1)
//
// Build option:
//   LED_FADER_GAMMA_EN  when defined, duty = (level*level) >> PWM_BITS through
//                       one register stage (perceptually linear fades, one
//                       extra clock of duty latency). When undefined,
//                       duty = level with no multiplier.
// -----------------------------------------------------------------------------
module led_fader #(
    parameter int NUM_CH   = 8,
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] led_req,
    output logic [NUM_CH-1:0] led_out,
    output logic [NUM_CH-1:0] fading
);

    localparam logic [PWM_BITS-1:0] MAX_LEVEL = {PWM_BITS{1'b1}};

    // A prescaler of one state still needs a 1-bit register to stay legal.
    localparam int               PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NUM_CH-1:0]   req_q,     req_d;
    logic [PRE_W-1:0]    pre_q,     pre_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] level_q [NUM_CH];
    logic [PWM_BITS-1:0] level_d [NUM_CH];
    logic [NUM_CH-1:0]   led_out_q, led_out_d;

    logic                step_tick;
    logic [PWM_BITS-1:0] duty [NUM_CH];

    // -------------------------------------------------------------------------
    // Input stage and shared timebases
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a value on every path
    // (here the first statement), otherwise synthesis infers a latch.
    always_comb begin
        req_d     = led_req;
        step_tick = (pre_q == PRE_LAST);
        pre_d     = step_tick ? '0 : pre_q + PRE_W'(1);
        // The PWM counter wraps MAX -> 0 naturally at PWM_BITS width.
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    end

    // -------------------------------------------------------------------------
    // Per-channel brightness level: one saturating step per step_tick toward
    // the registered request. A reversed request simply steps the other way
    // from wherever the level is now.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            level_d[i] = level_q[i];
            if (step_tick) begin
                if (req_q[i] && (level_q[i] != MAX_LEVEL)) begin
                    level_d[i] = level_q[i] + PWM_BITS'(1);
                end else if (!req_q[i] && (level_q[i] != '0)) begin
                    level_d[i] = level_q[i] - PWM_BITS'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Duty mapping
    // -------------------------------------------------------------------------
`ifdef LED_FADER_GAMMA_EN
    logic [PWM_BITS-1:0] duty_q [NUM_CH];
    logic [PWM_BITS-1:0] duty_d [NUM_CH];

    // Square law on the full 2*PWM_BITS product, keeping the upper half.
    function automatic logic [PWM_BITS-1:0] gamma_of(input logic [PWM_BITS-1:0] lvl);
        logic [2*PWM_BITS-1:0] prod;
        prod     = {{PWM_BITS{1'b0}}, lvl} * {{PWM_BITS{1'b0}}, lvl};
        gamma_of = PWM_BITS'(prod >> PWM_BITS);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            duty_d[i] = gamma_of(level_q[i]);
            duty[i]   = duty_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i] <= duty_d[i];
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            duty[i] = level_q[i];
        end
    end
`endif

    // -------------------------------------------------------------------------
    // PWM compare and fading status. The compare sees the level/duty as it is
    // before this clock's update, so a step_tick landing on a PWM wrap is
    // reflected one clock later.
    // -------------------------------------------------------------------------
    always_comb begin
        led_out_d = '0;
        fading    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            led_out_d[i] = (duty[i] > pwm_cnt_q);
            fading[i]    = ( req_q[i] && (level_q[i] != MAX_LEVEL)) ||
                           (!req_q[i] && (level_q[i] != '0));
        end
    end

    assign led_out = led_out_q;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            pre_q     <= '0;
            pwm_cnt_q <= '0;
            led_out_q <= '0;
            // NOTE: the level array is a bank of flops, not a RAM, and a
            // reset mid-fade must restart every ramp from 0, so it is reset.
            for (int i = 0; i < NUM_CH; i++) begin
                level_q[i] <= '0;
            end
        end else begin
            req_q     <= req_d;
            pre_q     <= pre_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_out_q <= led_out_d;
            for (int i = 0; i < NUM_CH; i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

endmodule

// File: tb/tb_led_fader.sv
// -----------------------------------------------------------------------------
// tb_led_fader
//
// Drives two led_fader instances (PWM_BITS=4, NUM_CH=8): dut with STEP_DIV=4
// for ramp/reversal/reset/random scenarios, dut2 with STEP_DIV=1024 so a level
// holds long enough to measure its PWM duty. Expected outputs of dut come from
// a cycle-level arithmetic model of the fade rules; duty windows of dut2 are
// compared against the expected on-count for the level reached.
// -----------------------------------------------------------------------------
module tb_led_fader;

    localparam int NCH = 8;
    localparam int PB  = 4;
    localparam int SD  = 4;
    localparam int SD2 = 1024;
    localparam int MAXL = (1 << PB) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] led_req = '0;
    logic [NCH-1:0] led_out;
    logic [NCH-1:0] fading;
    logic [NCH-1:0] led_req2 = '0;
    logic [NCH-1:0] led_out2;
    logic [NCH-1:0] fading2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_fader #(.NUM_CH(NCH), .PWM_BITS(PB), .STEP_DIV(SD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .led_req (led_req),
        .led_out (led_out),
        .fading  (fading)
    );

    led_fader #(.NUM_CH(NCH), .PWM_BITS(PB), .STEP_DIV(SD2)) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .led_req (led_req2),
        .led_out (led_out2),
        .fading  (fading2)
    );

    // ------------------------------------------------------------------ model
    int             m_lvl  [NCH];
    int             m_prev [NCH];
    logic [NCH-1:0] m_req;
    logic [NCH-1:0] m_out;
    logic [NCH-1:0] m_fad;
    int             m_n;

    function automatic int duty_of(input int lvl);
`ifdef LED_FADER_GAMMA_EN
        return (lvl * lvl) >> PB;
`else
        return lvl;
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) begin
            m_lvl[i]  = 0;
            m_prev[i] = 0;
        end
        m_req = '0;
        m_out = '0;
        m_fad = '0;
        m_n   = 0;
    endtask

    // One rising edge: m_n counts edges since reset release.
    task automatic model_edge();
        int  pwm;
        int  d;
        bit  tick;
        pwm  = m_n % (1 << PB);
        tick = ((m_n % SD) == SD - 1);
        for (int i = 0; i < NCH; i++) begin
`ifdef LED_FADER_GAMMA_EN
            d = duty_of(m_prev[i]);
`else
            d = duty_of(m_lvl[i]);
`endif
            m_out[i]  = (d > pwm);
            m_prev[i] = m_lvl[i];
        end
        if (tick) begin
            for (int i = 0; i < NCH; i++) begin
                if (m_req[i]) m_lvl[i] = (m_lvl[i] < MAXL) ? m_lvl[i] + 1 : MAXL;
                else          m_lvl[i] = (m_lvl[i] > 0)    ? m_lvl[i] - 1 : 0;
            end
        end
        m_req = led_req;
        for (int i = 0; i < NCH; i++) begin
            m_fad[i] = m_req[i] ? (m_lvl[i] != MAXL) : (m_lvl[i] != 0);
        end
        m_n++;
    endtask

    // ------------------------------------------------------------ utilities
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("led_out", 32'(led_out), 32'(m_out));
        check("fading",  32'(fading),  32'(m_fad));
    endtask

    // Asserts reset between clock edges, confirms outputs clear before the
    // next edge, then releases between edges so the next edge is edge 0.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("reset led_out",  32'(led_out),  32'h0);
        check("reset fading",   32'(fading),   32'h0);
        check("reset led_out2", 32'(led_out2), 32'h0);
        check("reset fading2",  32'(fading2),  32'h0);
        model_clear();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------- stimulus
    typedef struct {
        logic [NCH-1:0] req;
        int             cycles;
        logic [NCH-1:0] exp_fading;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int found;
        int done_at;
        int cnt;
        int e;
        int lv [3];
        logic [NCH-1:0] acc;

        // Phase table starting right after reset (STEP_DIV=4, ticks on
        // edges 3,7,11,...): ramp ch0 up, hand over ch0 -> ch7, then back.
        tbl[0] = '{8'h01,  1, 8'h01};  // fading rises 1 clk after sampling
        tbl[1] = '{8'h01, 58, 8'h01};  // level 14 after edge 58
        tbl[2] = '{8'h01,  1, 8'h00};  // level 15 at edge 59
        tbl[3] = '{8'h80, 70, 8'h00};  // ch0 down, ch7 up, both done
        tbl[4] = '{8'h01,  1, 8'h81};  // simultaneous reversal
        tbl[5] = '{8'h01, 56, 8'h81};  // 14 ticks in, still moving
        tbl[6] = '{8'h01,  1, 8'h00};  // 15th tick lands both

        do_reset();
        for (int p = 0; p < 7; p++) begin
            led_req = tbl[p].req;
            repeat (tbl[p].cycles) cyc();
            check($sformatf("table[%0d] fading", p), 32'(fading), 32'(tbl[p].exp_fading));
        end

        // Async reset mid-fade at level 10, then restart from 0.
        do_reset();
        led_req = 8'h01;
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            cyc();
            if (m_lvl[0] == 10 && m_out[0]) found = 1;
        end
        check("reach level 10", 32'(found), 32'd1);
        check("pre-reset led_out[0]", 32'(led_out[0]), 32'd1);
        do_reset();
        repeat (8) cyc();
        check("restart fading", 32'(fading), 32'h01);

        // Reversal at level 8: 8 further ticks (32 clks) down to 0.
        do_reset();
        led_req = 8'h01;
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            cyc();
            if (m_lvl[0] == 8) found = 1;
        end
        check("reach level 8", 32'(found), 32'd1);
        led_req = 8'h00;
        done_at = -1;
        for (int c = 1; c <= 100 && done_at < 0; c++) begin
            cyc();
            if (!fading[0]) done_at = c;
        end
        check("reversal length", 32'(done_at), 32'd32);
        acc = '0;
        repeat (16) begin
            cyc();
            acc = acc | led_out;
        end
        check("reversal off", 32'(acc), 32'h0);

        // Duty windows on dut2 at held levels 5, 8 and 15.
        led_req  = 8'h00;
        led_req2 = 8'h01;
        do_reset();
        lv[0] = 5;
        lv[1] = 8;
        lv[2] = 15;
        e = 0;
        for (int k = 0; k < 3; k++) begin
            while (e < lv[k] * SD2 + 4) begin
                cyc();
                e++;
            end
            cnt = 0;
            repeat (16) begin
                cyc();
                e++;
                cnt += int'(led_out2[0]);
            end
            check($sformatf("duty level %0d", lv[k]), 32'(cnt), 32'(duty_of(lv[k])));
            check($sformatf("fading2 level %0d", lv[k]), 32'(fading2),
                  (lv[k] == MAXL) ? 32'h0 : 32'h01);
        end
        led_req2 = 8'h00;

        // Randomized requests, including pulses shorter than a step period.
        do_reset();
        for (int r = 0; r < 80; r++) begin
            led_req = NCH'($urandom);
            repeat ($urandom_range(1, 40)) cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
